riscv_mem_arbiter: RTL and testbench

Shares the single memory port of the multicycle RISC-V core between the instruction-fetch requester and the load/store requester. It sits between `riscv_dp` and the memory, serialises accesses with a registered request/acknowledge handshake, and breaks ties round-robin. It also aborts any access the memory fails to acknowledge within a bounded number of cycles.

---
 rtl/riscv_mem_pkg.sv | 37 +++
 rtl/riscv_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
// Types and defaults shared by the memory arbiter of the multicycle RISC-V core:
// the arbiter state enum, the port-owner enum, default widths and the
// round-robin pick helper.
package riscv_mem_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int TIMEOUT_DEF    = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Round-robin choice between the two requesters. On a tie the port that
  // did not win last time is picked; with a single eligible port that port wins.
  function automatic owner_t rr_pick(input logic i_elig, input logic d_elig,
                                     input owner_t last_grant);
    owner_t pick;
    if (i_elig && d_elig) begin
      pick = (last_grant == OWN_I) ? OWN_D : OWN_I;
    end else if (d_elig) begin
      pick = OWN_D;
    end else begin
      pick = OWN_I;
    end
    return pick;
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
// Shares the single memory port between instruction fetch (i_*) and
// load/store (d_*). Accesses are serialised through IDLE -> BUSY -> DONE,
// ties are broken round-robin, and an access that sees no m_ack within
// TIMEOUT cycles of m_req is aborted with err=1.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   i_req/i_addr        fetch request (held until i_done) and address
//   i_rdata/i_done/i_err fetched word, completion pulse, timeout flag
//   d_req/d_we/d_addr/d_wdata  data request, store flag, address, store data
//   d_rdata/d_done/d_err load data, completion pulse, timeout flag
//   m_req/m_we/m_addr/m_wdata  memory request side (all registered)
//   m_rdata/m_ack       memory response, m_ack only sampled while m_req=1
//
// Every output is a flop; no input reaches an output combinationally.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_done,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  d_err,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_ack
);

  // The counter only has to hold 0..TIMEOUT-1: the abort is taken in the
  // cycle where it already sits at TIMEOUT-1 and m_ack is still low.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  arb_state_t state, state_nxt;
  owner_t     owner, owner_nxt;
  owner_t     last_grant, last_grant_nxt;
  owner_t     grant;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

  logic                  m_req_nxt, m_we_nxt;
  logic [ADDR_WIDTH-1:0] m_addr_nxt;
  logic [DATA_WIDTH-1:0] m_wdata_nxt;
  logic [DATA_WIDTH-1:0] i_rdata_nxt, d_rdata_nxt;
  logic                  i_done_nxt, d_done_nxt, i_err_nxt, d_err_nxt;
  logic                  i_elig, d_elig;

  // A port pulsing done this cycle still has its req high; mask it so the
  // held request is not taken as a fresh one.
  assign i_elig = i_req & ~i_done;
  assign d_elig = d_req & ~d_done;

  // Next-state and next-output logic for the arbiter FSM and its datapath.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    wait_cnt_nxt   = wait_cnt;
    m_req_nxt      = m_req;
    m_we_nxt       = m_we;
    m_addr_nxt     = m_addr;
    m_wdata_nxt    = m_wdata;
    i_rdata_nxt    = i_rdata;
    d_rdata_nxt    = d_rdata;
    i_done_nxt     = 1'b0;
    d_done_nxt     = 1'b0;
    i_err_nxt      = 1'b0;
    d_err_nxt      = 1'b0;
    grant          = rr_pick(i_elig, d_elig, last_grant);

    case (state)
      ST_IDLE: begin
        if (i_elig || d_elig) begin
          state_nxt      = ST_BUSY;
          owner_nxt      = grant;
          last_grant_nxt = grant;
          wait_cnt_nxt   = CNT_ZERO;
          m_req_nxt      = 1'b1;
          if (grant == OWN_D) begin
            m_we_nxt    = d_we;
            m_addr_nxt  = d_addr;
            m_wdata_nxt = d_wdata;
          end else begin
            m_we_nxt    = 1'b0;
            m_addr_nxt  = i_addr;
            m_wdata_nxt = {DATA_WIDTH{1'b0}};
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_BUSY: begin
        if (m_ack) begin
          // An ack in the final allowed cycle still wins over the abort.
          state_nxt = ST_DONE;
          m_req_nxt = 1'b0;
          if (owner == OWN_D) begin
            d_done_nxt = 1'b1;
            if (!m_we) begin
              d_rdata_nxt = m_rdata;
            end else begin
              d_rdata_nxt = d_rdata;
            end
          end else begin
            i_done_nxt  = 1'b1;
            i_rdata_nxt = m_rdata;
          end
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt = ST_DONE;
          m_req_nxt = 1'b0;
          if (owner == OWN_D) begin
            d_done_nxt = 1'b1;
            d_err_nxt  = 1'b1;
          end else begin
            i_done_nxt = 1'b1;
            i_err_nxt  = 1'b1;
          end
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_ONE;
        end
      end

      ST_DONE: begin
        state_nxt    = ST_IDLE;
        wait_cnt_nxt = CNT_ZERO;
      end

      default: begin
        state_nxt    = ST_IDLE;
        m_req_nxt    = 1'b0;
        wait_cnt_nxt = CNT_ZERO;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_I;
      last_grant <= OWN_D;
      wait_cnt   <= CNT_ZERO;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= {ADDR_WIDTH{1'b0}};
      m_wdata    <= {DATA_WIDTH{1'b0}};
      i_rdata    <= {DATA_WIDTH{1'b0}};
      d_rdata    <= {DATA_WIDTH{1'b0}};
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      i_err      <= 1'b0;
      d_err      <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      wait_cnt   <= wait_cnt_nxt;
      m_req      <= m_req_nxt;
      m_we       <= m_we_nxt;
      m_addr     <= m_addr_nxt;
      m_wdata    <= m_wdata_nxt;
      i_rdata    <= i_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      i_done     <= i_done_nxt;
      d_done     <= d_done_nxt;
      i_err      <= i_err_nxt;
      d_err      <= d_err_nxt;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter
// Self-checking bench for riscv_mem_arbiter with TIMEOUT=4: a table of
// single-access vectors, hand-written multi-cycle sequences (round-robin,
// reset mid-access, dropped request), and a randomized run against a
// transaction-timeline reference model.
module tb_riscv_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_done, i_err;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_done, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_req, m_we, m_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          delay;      // ack in this BUSY cycle; 0 = never
    bit          exp_err;
    logic [31:0] exp_rdata;  // owner's rdata in its done cycle
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    m_ack = 1'b0; m_rdata = '0;
    tick();
    tick();
    check("reset ctrl", {m_req, m_we, i_done, i_err, d_done, d_err}, 6'b0);
    check("reset m_addr", m_addr, 32'h0);
    check("reset m_wdata", m_wdata, 32'h0);
    check("reset i_rdata", i_rdata, 32'h0);
    check("reset d_rdata", d_rdata, 32'h0);
    reset = 1'b0;
  endtask

  // One access from idle; cycle 0 is the request cycle.
  task automatic run_vec(input vec_t v, input int idx);
    int endc;
    endc = (v.delay == 0 || v.delay > TO) ? TO : v.delay;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    tick();
    for (int c = 1; c <= endc + 2; c++) begin
      m_ack   = (c == v.delay);
      m_rdata = (c == v.delay) ? v.mdata : 32'h5A5A_0000 + 32'(c);
      check($sformatf("v%0d c%0d m_req", idx, c), m_req, (c <= endc));
      if (c <= endc) begin
        check($sformatf("v%0d c%0d m_addr", idx, c), m_addr, v.addr);
        check($sformatf("v%0d c%0d m_we", idx, c), m_we, v.we);
        if (v.we) check($sformatf("v%0d c%0d m_wdata", idx, c), m_wdata, v.wdata);
      end
      check($sformatf("v%0d c%0d i_done", idx, c), i_done, (!v.is_d && c == endc + 1));
      check($sformatf("v%0d c%0d d_done", idx, c), d_done, (v.is_d && c == endc + 1));
      if (c == endc + 1) begin
        if (v.is_d) begin
          check($sformatf("v%0d d_err", idx), d_err, v.exp_err);
          check($sformatf("v%0d d_rdata", idx), d_rdata, v.exp_rdata);
          d_req = 1'b0;
        end else begin
          check($sformatf("v%0d i_err", idx), i_err, v.exp_err);
          check($sformatf("v%0d i_rdata", idx), i_rdata, v.exp_rdata);
          i_req = 1'b0;
        end
      end
      tick();
    end
    m_ack = 1'b0;
  endtask

  // Reference-model state for the randomized run, in "cycles since grant".
  bit          busy, own, last, ip, dp, idrop, ddrop, t_we;
  int          since, delay, endc;
  logic [31:0] e_addr, e_wdata, e_ir, e_dr;
  bit          e_mreq, e_idone, e_ddone, e_to;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 1'b1, 32'h40,  32'h12345678, 32'hFFFF0000, 4, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h80,  32'h0,        32'hCAFEF00D, 2, 1'b0, 32'hCAFEF00D};
    tbl[3] = '{1'b1, 1'b0, 32'h84,  32'h0,        32'h99999999, 0, 1'b1, 32'hCAFEF00D};
    tbl[4] = '{1'b1, 1'b0, 32'h88,  32'h0,        32'h0BADCAFE, 1, 1'b0, 32'h0BADCAFE};
    tbl[5] = '{1'b0, 1'b0, 32'h104, 32'h0,        32'h77777777, 0, 1'b1, 32'hDEADBEEF};
    tbl[6] = '{1'b0, 1'b0, 32'h108, 32'h0,        32'h13579BDF, 3, 1'b0, 32'h13579BDF};
    tbl[7] = '{1'b1, 1'b1, 32'h8C,  32'hA5A5A5A5, 32'h11111111, 1, 1'b0, 32'h0BADCAFE};

    do_reset();
    for (int k = 0; k < 8; k++) run_vec(tbl[k], k);

    // Both requesters held from the first cycle after reset: I, D, I, D.
    do_reset();
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    m_ack = 1'b1; m_rdata = 32'h1;
    for (int c = 0; c < 12; c++) begin
      check($sformatf("rr c%0d i_done", c), i_done, (c % 3 == 2) && ((c / 3) % 2 == 0));
      check($sformatf("rr c%0d d_done", c), d_done, (c % 3 == 2) && ((c / 3) % 2 == 1));
      if (c % 3 == 1) check($sformatf("rr c%0d m_addr", c), m_addr, ((c / 3) % 2 == 0) ? 32'h200 : 32'h300);
      tick();
    end
    i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    tick();

    // Reset in the middle of a BUSY fetch, then a tie must go to I.
    i_req = 1'b1; i_addr = 32'h400;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rst busy m_req", m_req, 1'b0);
    check("rst busy i_done", i_done, 1'b0);
    tick();
    reset = 1'b0;
    check("rst after i_done", i_done, 1'b0);
    i_addr = 32'h404;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'hFEEDFACE;
    m_ack = 1'b1;
    tick();
    check("rst tie m_addr", m_addr, 32'h404);
    check("rst tie m_we", m_we, 1'b0);
    tick();
    check("rst tie i_done", i_done, 1'b1);
    check("rst tie i_err", i_err, 1'b0);
    check("rst tie d_done", d_done, 1'b0);
    i_req = 1'b0;
    tick();
    tick();
    check("rst d m_addr", m_addr, 32'h500);
    check("rst d m_wdata", m_wdata, 32'hFEEDFACE);
    tick();
    check("rst d_done", d_done, 1'b1);
    d_req = 1'b0; m_ack = 1'b0;
    tick();
    tick();

    // Requester drops req mid-access: access completes, no re-grant.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    tick();
    tick();
    d_req = 1'b0;
    tick();
    m_ack = 1'b1; m_rdata = 32'h0000_0077;
    tick();
    m_ack = 1'b0;
    check("drop d_done", d_done, 1'b1);
    check("drop d_rdata", d_rdata, 32'h77);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("drop after c%0d m_req", c), m_req, 1'b0);
      check($sformatf("drop after c%0d d_done", c), d_done, 1'b0);
    end

    // Randomized run against the timeline model.
    do_reset();
    busy = 1'b0; last = 1'b1; own = 1'b0; since = 0; delay = 1; endc = 1;
    ip = 1'b0; dp = 1'b0; idrop = 1'b0; ddrop = 1'b0; t_we = 1'b0;
    e_addr = '0; e_wdata = '0; e_ir = '0; e_dr = '0;
    for (int n = 0; n < 3000; n++) begin
      e_mreq  = busy && since >= 1 && since <= endc;
      e_idone = busy && since == endc + 1 && !own;
      e_ddone = busy && since == endc + 1 && own;
      e_to    = delay > TO;
      check($sformatf("rnd %0d ctrl", n), {m_req, i_done, i_err, d_done, d_err},
            {e_mreq, e_idone, e_idone && e_to, e_ddone, e_ddone && e_to});
      if (e_mreq) begin
        check($sformatf("rnd %0d m_addr", n), m_addr, e_addr);
        check($sformatf("rnd %0d m_we", n), m_we, t_we);
        if (t_we) check($sformatf("rnd %0d m_wdata", n), m_wdata, e_wdata);
      end
      check($sformatf("rnd %0d i_rdata", n), i_rdata, e_ir);
      check($sformatf("rnd %0d d_rdata", n), d_rdata, e_dr);

      if (e_idone) begin ip = 1'b0; idrop = 1'b0; end
      if (e_ddone) begin dp = 1'b0; ddrop = 1'b0; end
      if (!ip && $urandom_range(2) == 0) begin
        ip = 1'b1; i_addr = $urandom;
      end
      if (!dp && $urandom_range(2) == 0) begin
        dp = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(1));
      end
      if (e_mreq && !own && $urandom_range(7) == 0) idrop = 1'b1;
      if (e_mreq && own && $urandom_range(7) == 0) ddrop = 1'b1;
      i_req = ip && !idrop;
      d_req = dp && !ddrop;

      m_rdata = $urandom;
      if (e_mreq) m_ack = (since == delay);
      else        m_ack = 1'($urandom_range(1));

      if (busy) begin
        if (since == delay && delay <= TO && !t_we) begin
          if (own) e_dr = m_rdata;
          else     e_ir = m_rdata;
        end
        if (since == endc + 1) busy = 1'b0;
        else                   since++;
      end else if (i_req || d_req) begin
        own   = (i_req && d_req) ? !last : d_req;
        last  = own;
        busy  = 1'b1;
        since = 1;
        e_addr  = own ? d_addr : i_addr;
        t_we    = own ? d_we : 1'b0;
        e_wdata = d_wdata;
        delay = $urandom_range(TO + 2, 1);
        endc  = (delay > TO) ? TO : delay;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
